// File: rtl/tl45_register_read_if.sv
// rtl/tl45_register_read_if.sv - decode-in / operand-out / forwarding bundle for the register-read stage
interface tl45_register_read_if #(
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_pc;
  logic [4:0]        i_opcode;
  logic [3:0]        i_dr;
  logic [3:0]        i_sr1;
  logic [3:0]        i_sr2;
  logic [DATA_W-1:0] i_imm;
  logic              i_imm_sel;
  logic              i_flush;

  logic [3:0]        o_dprf_ra1;
  logic [3:0]        o_dprf_ra2;
  logic [DATA_W-1:0] i_dprf_d1;
  logic [DATA_W-1:0] i_dprf_d2;

  logic              i_fwd_ex_valid;
  logic [3:0]        i_fwd_ex_reg;
  logic [DATA_W-1:0] i_fwd_ex_value;
  logic              i_fwd_ex_is_load;
  logic              i_fwd_mem_valid;
  logic [3:0]        i_fwd_mem_reg;
  logic [DATA_W-1:0] i_fwd_mem_value;

  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_pc;
  logic [4:0]        o_opcode;
  logic [3:0]        o_dr;
  logic [DATA_W-1:0] o_imm;
  logic [DATA_W-1:0] o_a;
  logic [DATA_W-1:0] o_b;
  logic [31:0]       o_hazard_cycles;

  // slave: the register-read stage itself
  modport slave (
    input  i_valid, i_pc, i_opcode, i_dr, i_sr1, i_sr2, i_imm, i_imm_sel, i_flush,
    input  i_dprf_d1, i_dprf_d2,
    input  i_fwd_ex_valid, i_fwd_ex_reg, i_fwd_ex_value, i_fwd_ex_is_load,
    input  i_fwd_mem_valid, i_fwd_mem_reg, i_fwd_mem_value,
    input  i_ready,
    output o_ready, o_dprf_ra1, o_dprf_ra2,
    output o_valid, o_pc, o_opcode, o_dr, o_imm, o_a, o_b, o_hazard_cycles
  );

  // master: decode, register file, forwarding sources and EX around the stage
  modport master (
    output i_valid, i_pc, i_opcode, i_dr, i_sr1, i_sr2, i_imm, i_imm_sel, i_flush,
    output i_dprf_d1, i_dprf_d2,
    output i_fwd_ex_valid, i_fwd_ex_reg, i_fwd_ex_value, i_fwd_ex_is_load,
    output i_fwd_mem_valid, i_fwd_mem_reg, i_fwd_mem_value,
    output i_ready,
    input  o_ready, o_dprf_ra1, o_dprf_ra2,
    input  o_valid, o_pc, o_opcode, o_dr, o_imm, o_a, o_b, o_hazard_cycles
  );
endinterface

// File: rtl/tl45_register_read.sv
// rtl/tl45_register_read.sv - tl45 operand fetch: DPRF read, EX/MEM forwarding, load-use stall, registered output
module tl45_register_read #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  tl45_register_read_if.slave  rr
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [3:0]        dr_q, dr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [31:0]       hazard_cycles_q, hazard_cycles_d;

  logic              slot_free;
  logic              hazard;
  logic              ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  // r0 is hardwired zero; EX beats MEM beats the register file. MEM must be
  // forwarded because the DPRF read happens before that same-edge write lands.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [3:0]        r,
    input logic [DATA_W-1:0] dprf,
    input logic              ex_ok,
    input logic [3:0]        ex_reg,
    input logic [DATA_W-1:0] ex_val,
    input logic              mem_ok,
    input logic [3:0]        mem_reg,
    input logic [DATA_W-1:0] mem_val
  );
    if (r == 4'd0)                        return '0;
    else if (ex_ok && ex_reg == r)        return ex_val;
    else if (mem_ok && mem_reg == r)      return mem_val;
    else                                  return dprf;
  endfunction

  always_comb begin
    slot_free = !valid_q || rr.i_ready;
    hazard    = rr.i_valid && rr.i_fwd_ex_valid && rr.i_fwd_ex_is_load &&
                (rr.i_fwd_ex_reg != 4'd0) &&
                ((rr.i_fwd_ex_reg == rr.i_sr1) ||
                 (!rr.i_imm_sel && (rr.i_fwd_ex_reg == rr.i_sr2)));
    ready     = slot_free && !hazard && !rr.i_flush;

    op_a = resolve(rr.i_sr1, rr.i_dprf_d1,
                   rr.i_fwd_ex_valid && !rr.i_fwd_ex_is_load, rr.i_fwd_ex_reg, rr.i_fwd_ex_value,
                   rr.i_fwd_mem_valid, rr.i_fwd_mem_reg, rr.i_fwd_mem_value);
    op_b = rr.i_imm_sel ? rr.i_imm :
           resolve(rr.i_sr2, rr.i_dprf_d2,
                   rr.i_fwd_ex_valid && !rr.i_fwd_ex_is_load, rr.i_fwd_ex_reg, rr.i_fwd_ex_value,
                   rr.i_fwd_mem_valid, rr.i_fwd_mem_reg, rr.i_fwd_mem_value);
  end

  always_comb begin
    valid_d         = valid_q;
    pc_d            = pc_q;
    opcode_d        = opcode_q;
    dr_d            = dr_q;
    imm_d           = imm_q;
    a_d             = a_q;
    b_d             = b_q;
    hazard_cycles_d = hazard_cycles_q;

    if (rr.i_flush) begin
      valid_d = 1'b0;
    end else if (rr.i_valid && ready) begin
      valid_d  = 1'b1;
      pc_d     = rr.i_pc;
      opcode_d = rr.i_opcode;
      dr_d     = rr.i_dr;
      imm_d    = rr.i_imm;
      a_d      = op_a;
      b_d      = op_b;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end

    // Only stalls that actually cost a slot are counted; a downstream stall hides the hazard.
    if (hazard && slot_free && !rr.i_flush) begin
      hazard_cycles_d = hazard_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= 1'b0;
      pc_q            <= '0;
      opcode_q        <= '0;
      dr_q            <= '0;
      imm_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      hazard_cycles_q <= '0;
    end else begin
      valid_q         <= valid_d;
      pc_q            <= pc_d;
      opcode_q        <= opcode_d;
      dr_q            <= dr_d;
      imm_q           <= imm_d;
      a_q             <= a_d;
      b_q             <= b_d;
      hazard_cycles_q <= hazard_cycles_d;
    end
  end

  assign rr.o_ready         = ready;
  assign rr.o_dprf_ra1      = rr.i_sr1;
  assign rr.o_dprf_ra2      = rr.i_sr2;
  assign rr.o_valid         = valid_q;
  assign rr.o_pc            = pc_q;
  assign rr.o_opcode        = opcode_q;
  assign rr.o_dr            = dr_q;
  assign rr.o_imm           = imm_q;
  assign rr.o_a             = a_q;
  assign rr.o_b             = b_q;
  assign rr.o_hazard_cycles = hazard_cycles_q;

endmodule

// File: tb/tb_tl45_register_read.sv
// tb/tb_tl45_register_read.sv - directed vector table plus randomized model check of tl45_register_read
module tb_tl45_register_read;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tl45_register_read_if bus ();

  tl45_register_read dut (
    .clk   (clk),
    .reset (reset),
    .rr    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, valid, flush, imm_sel, ready, ex_v, ex_ld, mem_v;
    logic [3:0]  sr1, sr2, ex_r, mem_r;
    logic [31:0] pc, imm, d1, d2, ex_val, mem_val;
    logic        chk_rdy, e_rdy, e_valid;
    logic [31:0] e_a, e_b, e_pc, e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic [3:0] sr1,
                              input logic [3:0] sr2, input logic [31:0] d1, input logic [31:0] d2);
    vec_t v;
    v.rst = 0; v.valid = valid; v.flush = 0; v.imm_sel = 0; v.ready = 1;
    v.ex_v = 0; v.ex_ld = 0; v.mem_v = 0;
    v.sr1 = sr1; v.sr2 = sr2; v.ex_r = 0; v.mem_r = 0;
    v.pc = pc; v.imm = 0; v.d1 = d1; v.d2 = d2; v.ex_val = 0; v.mem_val = 0;
    v.chk_rdy = 1; v.e_rdy = 0; v.e_valid = 0;
    v.e_a = 0; v.e_b = 0; v.e_pc = 0; v.e_cnt = 0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic rdy, input logic val, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] pc, input logic [31:0] cnt);
    vec_t v = vi;
    v.e_rdy = rdy; v.e_valid = val; v.e_a = a; v.e_b = b; v.e_pc = pc; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic [4:0] opc, input logic [3:0] dr);
    reset                = v.rst;
    bus.i_valid          = v.valid;
    bus.i_pc             = v.pc;
    bus.i_opcode         = opc;
    bus.i_dr             = dr;
    bus.i_sr1            = v.sr1;
    bus.i_sr2            = v.sr2;
    bus.i_imm            = v.imm;
    bus.i_imm_sel        = v.imm_sel;
    bus.i_flush          = v.flush;
    bus.i_dprf_d1        = v.d1;
    bus.i_dprf_d2        = v.d2;
    bus.i_fwd_ex_valid   = v.ex_v;
    bus.i_fwd_ex_reg     = v.ex_r;
    bus.i_fwd_ex_value   = v.ex_val;
    bus.i_fwd_ex_is_load = v.ex_ld;
    bus.i_fwd_mem_valid  = v.mem_v;
    bus.i_fwd_mem_reg    = v.mem_r;
    bus.i_fwd_mem_value  = v.mem_val;
    bus.i_ready          = v.ready;
  endtask

  // Reference: forwarding candidates tried in priority order, first match wins.
  function automatic logic [31:0] pick(input vec_t v, input logic [3:0] r, input logic [31:0] dprf);
    logic        ok  [3];
    logic [31:0] val [3];
    if (r == 0) return 32'd0;
    ok[0] = v.ex_v && !v.ex_ld && v.ex_r == r;  val[0] = v.ex_val;
    ok[1] = v.mem_v && v.mem_r == r;            val[1] = v.mem_val;
    ok[2] = 1'b1;                               val[2] = dprf;
    for (int k = 0; k < 3; k++) if (ok[k]) return val[k];
    return 32'd0;
  endfunction

  logic        m_valid;
  logic [31:0] m_pc, m_imm, m_a, m_b, m_cnt;
  logic [4:0]  m_opc;
  logic [3:0]  m_dr;

  initial begin
    vec_t v;
    // directed sequence; each entry's expectation follows from the one before it
    v = mk(0, 0, 0, 0, 0, 0); v.rst = 1; v.chk_rdy = 0;
    tbl.push_back(ex(v, 0, 0, 0, 0, 0, 0));
    v = mk(1, 32'h100, 3, 4, 32'h11, 32'h22);
    tbl.push_back(ex(v, 1, 1, 32'h11, 32'h22, 32'h100, 0));
    v = mk(1, 32'h104, 5, 0, 32'h99, 0);
    v.ex_v = 1; v.ex_r = 5; v.ex_val = 32'hAAAA; v.mem_v = 1; v.mem_r = 5; v.mem_val = 32'hBBBB;
    tbl.push_back(ex(v, 1, 1, 32'hAAAA, 0, 32'h104, 0));
    v.ex_v = 0; v.pc = 32'h108;
    tbl.push_back(ex(v, 1, 1, 32'hBBBB, 0, 32'h108, 0));
    v = mk(1, 32'h10C, 0, 0, 32'h1234, 32'h5678);
    v.ex_v = 1; v.ex_r = 0; v.ex_val = 32'hFFFF;
    tbl.push_back(ex(v, 1, 1, 0, 0, 32'h10C, 0));
    v = mk(1, 32'h110, 0, 9, 32'h1, 32'h333); v.imm_sel = 1; v.imm = 7;
    tbl.push_back(ex(v, 1, 1, 0, 7, 32'h110, 0));
    v = mk(1, 32'h114, 1, 2, 32'h10, 32'hDEAD); v.ex_v = 1; v.ex_ld = 1; v.ex_r = 2;
    tbl.push_back(ex(v, 0, 0, 0, 7, 32'h110, 1));
    v.ex_v = 0; v.ex_ld = 0; v.mem_v = 1; v.mem_r = 2; v.mem_val = 32'h55;
    tbl.push_back(ex(v, 1, 1, 32'h10, 32'h55, 32'h114, 1));
    v = mk(1, 32'h118, 3, 2, 32'h77, 0); v.imm_sel = 1; v.imm = 32'h42;
    v.ex_v = 1; v.ex_ld = 1; v.ex_r = 2;
    tbl.push_back(ex(v, 1, 1, 32'h77, 32'h42, 32'h118, 1));
    v = mk(1, 32'h11C, 0, 0, 32'h5, 32'h6); v.ex_v = 1; v.ex_ld = 1; v.ex_r = 0;
    tbl.push_back(ex(v, 1, 1, 0, 0, 32'h11C, 1));
    v = mk(1, 32'h120, 1, 0, 32'h1, 0); v.ready = 0;
    for (int k = 0; k < 3; k++) tbl.push_back(ex(v, 0, 1, 0, 0, 32'h11C, 1));
    v.ready = 1;
    tbl.push_back(ex(v, 1, 1, 32'h1, 0, 32'h120, 1));
    v = mk(1, 32'h124, 1, 0, 32'h9, 0); v.ready = 0; v.ex_v = 1; v.ex_ld = 1; v.ex_r = 1;
    tbl.push_back(ex(v, 0, 1, 32'h1, 0, 32'h120, 1));
    v = mk(1, 32'h128, 3, 3, 32'h3, 32'h3); v.flush = 1;
    tbl.push_back(ex(v, 0, 0, 32'h1, 0, 32'h120, 1));
    v = mk(1, 32'h128, 1, 0, 32'h3, 0); v.flush = 1; v.ex_v = 1; v.ex_ld = 1; v.ex_r = 1;
    tbl.push_back(ex(v, 0, 0, 32'h1, 0, 32'h120, 1));
    v = mk(1, 32'h12C, 2, 0, 32'h2, 0);
    tbl.push_back(ex(v, 1, 1, 32'h2, 0, 32'h12C, 1));
    v = mk(1, 32'h130, 2, 0, 32'h8, 0); v.ready = 0;
    tbl.push_back(ex(v, 0, 1, 32'h2, 0, 32'h12C, 1));
    v.rst = 1; v.chk_rdy = 0;
    tbl.push_back(ex(v, 0, 0, 0, 0, 0, 0));

    v = mk(0, 0, 0, 0, 0, 0); v.rst = 1;
    drive(v, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset o_valid", {31'd0, bus.o_valid}, 0);
    chk("reset o_hazard_cycles", bus.o_hazard_cycles, 0);

    foreach (tbl[i]) begin
      drive(tbl[i], tbl[i].pc[6:2], tbl[i].pc[5:2]);
      #1;
      if (tbl[i].chk_rdy) chk($sformatf("v%0d o_ready", i), {31'd0, bus.o_ready}, {31'd0, tbl[i].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d o_valid", i), {31'd0, bus.o_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d o_a", i), bus.o_a, tbl[i].e_a);
      chk($sformatf("v%0d o_b", i), bus.o_b, tbl[i].e_b);
      chk($sformatf("v%0d o_pc", i), bus.o_pc, tbl[i].e_pc);
      chk($sformatf("v%0d o_hazard_cycles", i), bus.o_hazard_cycles, tbl[i].e_cnt);
    end

    // table ends in reset, so the model starts from the cleared state
    m_valid = 0; m_pc = 0; m_imm = 0; m_a = 0; m_b = 0; m_cnt = 0; m_opc = 0; m_dr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [4:0]  opc;
      logic [3:0]  dr;
      logic [3:0]  srcs[$];
      logic        slot, haz, e_rdy;
      v = mk($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, $urandom);
      v.rst     = ($urandom_range(0, 99) < 2);
      v.flush   = ($urandom_range(0, 9) == 0);
      v.imm_sel = ($urandom_range(0, 3) == 0);
      v.imm     = $urandom;
      v.ready   = ($urandom_range(0, 3) != 0);
      v.ex_v    = $urandom_range(0, 1);
      v.ex_ld   = ($urandom_range(0, 2) == 0);
      v.ex_r    = $urandom_range(0, 3);
      v.ex_val  = $urandom;
      v.mem_v   = $urandom_range(0, 1);
      v.mem_r   = $urandom_range(0, 3);
      v.mem_val = $urandom;
      opc = 5'($urandom);
      dr  = 4'($urandom);
      drive(v, opc, dr);

      slot = !m_valid || v.ready;
      srcs = {};
      srcs.push_back(v.sr1);
      if (!v.imm_sel) srcs.push_back(v.sr2);
      haz = 0;
      if (v.valid && v.ex_v && v.ex_ld && v.ex_r != 0)
        foreach (srcs[k]) if (srcs[k] == v.ex_r) haz = 1;
      e_rdy = slot && !haz && !v.flush;

      #1;
      chk("rand o_ready", {31'd0, bus.o_ready}, {31'd0, e_rdy});
      chk("rand o_dprf_ra1", {28'd0, bus.o_dprf_ra1}, {28'd0, v.sr1});
      chk("rand o_dprf_ra2", {28'd0, bus.o_dprf_ra2}, {28'd0, v.sr2});

      if (v.rst) begin
        m_valid = 0; m_pc = 0; m_imm = 0; m_a = 0; m_b = 0; m_cnt = 0; m_opc = 0; m_dr = 0;
      end else begin
        if (haz && slot && !v.flush) m_cnt = m_cnt + 1;
        if (v.flush) m_valid = 0;
        else if (v.valid && e_rdy) begin
          m_valid = 1; m_pc = v.pc; m_opc = opc; m_dr = dr; m_imm = v.imm;
          m_a = pick(v, v.sr1, v.d1);
          m_b = v.imm_sel ? v.imm : pick(v, v.sr2, v.d2);
        end else if (slot) m_valid = 0;
      end

      @(posedge clk);
      #1;
      chk("rand o_valid", {31'd0, bus.o_valid}, {31'd0, m_valid});
      chk("rand o_pc", bus.o_pc, m_pc);
      chk("rand o_opcode", {27'd0, bus.o_opcode}, {27'd0, m_opc});
      chk("rand o_dr", {28'd0, bus.o_dr}, {28'd0, m_dr});
      chk("rand o_imm", bus.o_imm, m_imm);
      chk("rand o_a", bus.o_a, m_a);
      chk("rand o_b", bus.o_b, m_b);
      chk("rand o_hazard_cycles", bus.o_hazard_cycles, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
